// File: rtl/cbc_decrypt_top.sv
// cbc_decrypt_top: AES-128 CBC decryptor. The inverse cipher is fully pipelined
// and accepts one 128-bit block per clock. The CBC chaining XOR is applied
// after the last inverse round.
//
// Ports (cbc_decrypt_top):
//   clk                       rising-edge clock
//   reset                     asynchronous, active-high
//   key                       round-0 (cipher) key, applied in the final round
//   round1_key..round10_key   expanded round keys, applied in reverse order
//   vector                    IV, loaded into the chain register on iv_load
//   iv_load                   start of message
//   in_valid / cipher_text    ciphertext block C_i; there is no backpressure
//   out_valid / plain_text    P_i = InvCipher(C_i) ^ C_(i-1), 10 clocks after input
//   block_count               blocks delivered since the last iv_load
//
// The file also holds the inverse-round primitives and the GF(2^8) helper
// package that the primitives use.

package cbc_decrypt_pkg;
  localparam logic [31:0] INV_MIX_COEF = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // The multiplicative inverse is computed as x^254, and 0 maps to 0. It depends
  // on 8 bits only, so each instance reduces to a 256-entry table in synthesis.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  // The inverse affine transform is applied first, then the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8]. The state is column-major,
  // so byte index = 4*column + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(INV_MIX_COEF[31 - 8*((j + 4 - r) % 4) -: 8],
                             s[127 - 8*(4*c + j) -: 8]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction
endpackage

// add_round_key: state ^ round_key.
module add_round_key (
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  assign result = state ^ round_key;
endmodule

// decrypt_round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module decrypt_round
  import cbc_decrypt_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  assign result = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state)) ^ round_key);
endmodule

// decrypt_final_round: InvShiftRows, InvSubBytes, AddRoundKey. No InvMixColumns.
module decrypt_final_round
  import cbc_decrypt_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  assign result = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
endmodule

module cbc_decrypt_top #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [127:0]     key,
  input  logic [127:0]     round1_key,
  input  logic [127:0]     round2_key,
  input  logic [127:0]     round3_key,
  input  logic [127:0]     round4_key,
  input  logic [127:0]     round5_key,
  input  logic [127:0]     round6_key,
  input  logic [127:0]     round7_key,
  input  logic [127:0]     round8_key,
  input  logic [127:0]     round9_key,
  input  logic [127:0]     round10_key,
  input  logic [127:0]     vector,
  input  logic             iv_load,
  input  logic             in_valid,
  input  logic [127:0]     cipher_text,
  output logic             out_valid,
  output logic [127:0]     plain_text,
  output logic [CNT_W-1:0] block_count
);
  logic [127:0] stage_key  [1:9];  // stage k uses round(10-k)_key
  logic [127:0] round_in   [1:9];
  logic [127:0] round_out  [1:9];
  logic [127:0] data_pipe  [1:9];
  logic [127:0] chain_pipe [1:9];  // chain value that travels alongside data_pipe
  logic [127:0] ark_out;
  logic [127:0] final_out;
  logic [127:0] chain_reg;
  logic [127:0] chain_sel;
  logic [9:0]   valid_pipe;

  assign stage_key = '{round9_key, round8_key, round7_key, round6_key, round5_key,
                       round4_key, round3_key, round2_key, round1_key};

  // When iv_load arrives with a block, that block is the first of a new
  // message and chains with the new IV.
  assign chain_sel = iv_load ? vector : chain_reg;
  assign out_valid = valid_pipe[9];

  add_round_key u_ark (
    .state     (cipher_text),
    .round_key (round10_key),
    .result    (ark_out)
  );

  assign round_in[1] = ark_out;
  for (genvar k = 1; k <= 9; k++) begin : g_round
    if (k > 1) begin : g_link
      assign round_in[k] = data_pipe[k-1];
    end
    decrypt_round u_round (
      .state     (round_in[k]),
      .round_key (stage_key[k]),
      .result    (round_out[k])
    );
  end

  decrypt_final_round u_final (
    .state     (data_pipe[9]),
    .round_key (key),
    .result    (final_out)
  );

  // Nine data registers plus the plain_text register give the 10-clock latency.
  // chain_pipe[9] meets data_pipe[9] at the final XOR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the wide data pipeline is reset on purpose. A reset must flush every in-flight block and leave all outputs at 0.
      data_pipe   <= '{default: '0};
      chain_pipe  <= '{default: '0};
      valid_pipe  <= '0;
      chain_reg   <= '0;
      plain_text  <= '0;
      block_count <= '0;
    end else begin
      // NOTE: use only non-blocking assignments here so that every stage shifts from its pre-edge value.
      for (int k = 1; k <= 9; k++) data_pipe[k] <= round_out[k];
      chain_pipe[1] <= chain_sel;
      for (int k = 2; k <= 9; k++) chain_pipe[k] <= chain_pipe[k-1];
      valid_pipe <= {valid_pipe[8:0], in_valid};

      if (in_valid)     chain_reg <= cipher_text;
      else if (iv_load) chain_reg <= vector;

      if (valid_pipe[8]) plain_text <= final_out ^ chain_pipe[9];

      // An output that coincides with iv_load counts toward the new message.
      if (iv_load)        block_count <= out_valid ? CNT_W'(1) : '0;
      else if (out_valid) block_count <= block_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cbc_decrypt_top.sv
// tb_cbc_decrypt_top: scoreboard bench for cbc_decrypt_top. The driver pushes
// the expected plaintext for every accepted block. A negedge monitor compares
// out_valid, plain_text and block_count against a 10-clock timing model.
// Expected values for the random traffic come from a forward AES-128 CBC
// encryptor and key expansion, written independently in this file.
module tb_cbc_decrypt_top;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         iv_load = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] vector = '0;
  logic [127:0] cipher_text = '0;
  logic [127:0] rk [0:10];
  logic         out_valid;
  logic [127:0] plain_text;
  logic [15:0]  block_count;

  int           checks = 0;
  int           failures = 0;
  logic [127:0] exp_q [$];
  logic [9:0]   exp_pipe;
  logic [15:0]  exp_count;

  cbc_decrypt_top #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (rst),
    .key         (rk[0]),
    .round1_key  (rk[1]),
    .round2_key  (rk[2]),
    .round3_key  (rk[3]),
    .round4_key  (rk[4]),
    .round5_key  (rk[5]),
    .round6_key  (rk[6]),
    .round7_key  (rk[7]),
    .round8_key  (rk[8]),
    .round9_key  (rk[9]),
    .round10_key (rk[10]),
    .vector      (vector),
    .iv_load     (iv_load),
    .in_valid    (in_valid),
    .cipher_text (cipher_text),
    .out_valid   (out_valid),
    .plain_text  (plain_text),
    .block_count (block_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // ---------------- forward AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = mul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    return s ^ 8'h63;
  endfunction

  logic [7:0] sbox_tbl [256];

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox_tbl[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
      o[103 - 32*c -: 8] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= 9; r++) s = mix_cols(sub_shift(s)) ^ rk[r];
    return sub_shift(s) ^ rk[10];
  endfunction

  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]], sbox_tbl[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- timing model and monitor ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pipe  <= '0;
      exp_count <= '0;
    end else begin
      exp_pipe <= {exp_pipe[8:0], in_valid};
      if (iv_load)          exp_count <= exp_pipe[9] ? 16'd1 : 16'd0;
      else if (exp_pipe[9]) exp_count <= exp_count + 16'd1;
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, exp_pipe[9]);
    check("block_count", block_count, exp_count);
    if (exp_pipe[9]) begin
      check("sb_has_entry", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("plain_text", plain_text, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic ld, input logic [127:0] iv,
                       input logic [127:0] c, input logic [127:0] p);
    @(posedge clk);
    #1;
    in_valid    = v;
    iv_load     = ld;
    vector      = iv;
    cipher_text = c;
    if (v) exp_q.push_back(p);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, vector, rand128(), '0);
  endtask

  localparam logic [127:0] SP_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP_C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] SP_C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] SP_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  initial begin
    logic [127:0] iv_n, p_n, c_n, prev;
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox(8'(i));
    for (int r = 0; r <= 10; r++) rk[r] = '0;

    // Power-on reset
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_plain_text", plain_text, '0);
    check("reset_block_count", block_count, '0);

    // FIPS-197 C.1: single block, iv_load on its own first
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    drive(1'b0, 1'b1, '0, '0, '0);
    drive(1'b1, 1'b0, '0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    idle(12);
    check("fips_block_count", block_count, 16'd1);
    check("fips_plain_text_held", plain_text, 128'h00112233445566778899aabbccddeeff);

    // SP800-38A F.2.2 back-to-back, iv_load together with C1
    load_key(SP_KEY);
    drive(1'b1, 1'b1, SP_IV, SP_C1, SP_P1);
    drive(1'b1, 1'b0, SP_IV, SP_C2, SP_P2);
    idle(12);
    check("b2b_block_count", block_count, 16'd2);

    // Same vectors with 3 idle cycles (garbage ciphertext) between C1 and C2
    drive(1'b1, 1'b1, SP_IV, SP_C1, SP_P1);
    idle(3);
    drive(1'b1, 1'b0, SP_IV, SP_C2, SP_P2);
    idle(12);
    check("gap_block_count", block_count, 16'd2);

    // New message starts (iv_load + C1) while the old message is in flight
    iv_n = rand128();
    p_n  = rand128();
    c_n  = encrypt(p_n ^ iv_n);
    drive(1'b1, 1'b1, SP_IV, SP_C1, SP_P1);
    drive(1'b1, 1'b0, SP_IV, SP_C2, SP_P2);
    idle(2);
    drive(1'b1, 1'b1, iv_n, c_n, p_n);
    idle(9);
    // iv_load alone in the same cycle that the new P1 is delivered
    drive(1'b0, 1'b1, rand128(), rand128(), '0);
    idle(1);
    check("coincide_block_count", block_count, 16'd1);
    idle(3);

    // Reset 5 cycles after 3 blocks are fed: no output for any of them
    for (int i = 0; i < 3; i++) begin
      p_n = rand128();
      drive(1'b1, i == 0, SP_IV, encrypt(p_n ^ rand128()), p_n);
    end
    idle(5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    iv_load = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_plain_text", plain_text, '0);
      check("post_rst_block_count", block_count, '0);
    end

    // Random traffic: 1000 blocks, random key/IV, random idle gaps
    load_key(rand128());
    idle(1);
    prev = rand128();
    iv_n = prev;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      p_n  = rand128();
      c_n  = encrypt(p_n ^ prev);
      prev = c_n;
      drive(1'b1, i == 0, iv_n, c_n, p_n);
    end
    idle(12);
    check("rand_block_count", block_count, 16'(1000));
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
